// File: rtl/mul_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_arbiter_pkg                                               |
// | Description : Shared types and op encodings for the multiplier arbiter.    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+

// Fallbacks for the shared RISC-V defines; a prior include of riscv_defines.vh
// takes precedence because every definition is guarded.
`ifndef MUL_OP_WIDTH
`define MUL_OP_WIDTH 2
`endif
`ifndef MUL_OP_MUL
`define MUL_OP_MUL   2'b00
`endif
`ifndef MUL_OP_MULH
`define MUL_OP_MULH  2'b01
`endif
`ifndef MUL_OP_MULSU
`define MUL_OP_MULSU 2'b10
`endif
`ifndef MUL_OP_MULU
`define MUL_OP_MULU  2'b11
`endif

package mul_arbiter_pkg;

  localparam int OP_W = `MUL_OP_WIDTH;

  typedef logic [OP_W-1:0] mul_op_t;

  localparam mul_op_t MUL_OP_MUL   = `MUL_OP_MUL;
  localparam mul_op_t MUL_OP_MULH  = `MUL_OP_MULH;
  localparam mul_op_t MUL_OP_MULSU = `MUL_OP_MULSU;
  localparam mul_op_t MUL_OP_MULU  = `MUL_OP_MULU;

  // One multiply transaction: operands plus op, as sent downstream.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    mul_op_t     op;
  } mul_req_t;

  function automatic mul_req_t pack_req(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input mul_op_t     op);
    mul_req_t r;
    r.a  = a;
    r.b  = b;
    r.op = op;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_arbiter_if                                                |
// | Description : Requester and multiplier handshake bundle for mul_arbiter.   |
// |               slave = arbiter view, master = requesters + multiplier view. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface mul_arbiter_if;
  import mul_arbiter_pkg::*;

  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  mul_op_t     req0_op;
  logic        req0_ready;
  logic [31:0] req0_result;

  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  mul_op_t     req1_op;
  logic        req1_ready;
  logic [31:0] req1_result;

  logic        mul_valid;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  mul_op_t     mul_op;
  logic        mul_ready;
  logic [31:0] mul_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  mul_ready, mul_result,
    output req0_ready, req0_result, req1_ready, req1_result,
    output mul_valid, mul_a, mul_b, mul_op
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output mul_ready, mul_result,
    input  req0_ready, req0_result, req1_ready, req1_result,
    input  mul_valid, mul_a, mul_b, mul_op
  );
endinterface

`default_nettype wire

// File: rtl/mul_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arb2                                                       |
// | Description : 2-way round-robin grant; a tie goes to the requester that    |
// |               was not granted last.                                         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |valid;
  // Single requester wins outright; with both pending, alternate.
  assign gnt_idx   = (&valid) ? ~last_grant : valid[1];

endmodule

`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_arbiter                                                   |
// | Description : Shares one iterative multiplier between two requesters with  |
// |               round-robin grant and one transaction outstanding.           |
// |               Optional macro MUL_ARB_RESULT_CACHE_EN adds a one-entry      |
// |               result cache that bypasses the multiplier on a repeat op.    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mul_arbiter
  import mul_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  mul_arbiter_if.slave bus
);

  localparam int ST_W    = 4;
  localparam int S_IDLE  = 0;
  localparam int S_BUSY  = 1;
  localparam int S_DRAIN = 2;
  localparam int S_RESP  = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 4'b0001;
  localparam logic [ST_W-1:0] ST_BUSY  = 4'b0010;
  localparam logic [ST_W-1:0] ST_DRAIN = 4'b0100;
  localparam logic [ST_W-1:0] ST_RESP  = 4'b1000;

  logic [ST_W-1:0]  r_state, w_state_nxt;
  logic             r_last_grant, w_last_grant_nxt;
  logic             r_grant, w_grant_nxt;
  logic             w_gnt_valid, w_gnt_idx, w_gnt_req_valid;
  mul_req_t         w_sel_req, r_mul_req, w_mul_req_nxt;
  logic             r_mul_valid, w_mul_valid_nxt;
  logic [31:0]      r_mul_res, w_mul_res_nxt;
  logic [1:0]       r_ready, w_ready_nxt;
  logic [1:0][31:0] r_result, w_result_nxt;
  logic             w_cache_hit;
  logic [31:0]      w_cache_res;

  rr_arb2 u_rr_arb2 (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_idx    (w_gnt_idx)
  );

  assign w_sel_req = w_gnt_idx ? pack_req(bus.req1_a, bus.req1_b, bus.req1_op)
                               : pack_req(bus.req0_a, bus.req0_b, bus.req0_op);
  // Valid of whichever requester owns the in-flight transaction.
  assign w_gnt_req_valid = r_grant ? bus.req1_valid : bus.req0_valid;

`ifdef MUL_ARB_RESULT_CACHE_EN
  logic        r_cache_vld;
  mul_req_t    r_cache_req;
  logic [31:0] r_cache_res;
  logic        w_cache_wr;

  // Every real multiplier completion refreshes the cache, abandoned or not.
  assign w_cache_wr = r_state[S_BUSY] && bus.mul_ready;

  // One-entry cache of the last completed {a, b, op, result}.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cache_vld <= 1'b0;
      r_cache_req <= '0;
      r_cache_res <= '0;
    end else if (w_cache_wr) begin
      r_cache_vld <= 1'b1;
      r_cache_req <= r_mul_req;
      r_cache_res <= bus.mul_result;
    end
  end

  assign w_cache_hit = r_cache_vld && (r_cache_req == w_sel_req);
  assign w_cache_res = r_cache_res;
`else
  assign w_cache_hit = 1'b0;
  assign w_cache_res = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode; an illegal encoding falls back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state[S_IDLE]) begin
      if (w_gnt_valid) w_state_nxt = w_cache_hit ? ST_RESP : ST_BUSY;
    end else if (r_state[S_BUSY]) begin
      if (bus.mul_ready) w_state_nxt = ST_DRAIN;
    end else if (r_state[S_DRAIN]) begin
      if (!bus.mul_ready) w_state_nxt = w_gnt_req_valid ? ST_RESP : ST_IDLE;
    end else if (r_state[S_RESP]) begin
      if (!w_gnt_req_valid) w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    w_mul_valid_nxt  = r_mul_valid;
    w_mul_req_nxt    = r_mul_req;
    w_mul_res_nxt    = r_mul_res;
    w_ready_nxt      = r_ready;
    w_result_nxt     = r_result;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    if (r_state[S_IDLE]) begin
      if (w_gnt_valid) begin
        w_grant_nxt = w_gnt_idx;
        if (w_cache_hit) begin
          w_ready_nxt[w_gnt_idx]  = 1'b1;
          w_result_nxt[w_gnt_idx] = w_cache_res;
        end else begin
          w_mul_valid_nxt = 1'b1;
          w_mul_req_nxt   = w_sel_req;
        end
      end
    end else if (r_state[S_BUSY]) begin
      if (bus.mul_ready) begin
        w_mul_valid_nxt = 1'b0;
        w_mul_res_nxt   = bus.mul_result;
      end
    end else if (r_state[S_DRAIN]) begin
      // An abandoned request simply never gets its ready pulse.
      if (!bus.mul_ready && w_gnt_req_valid) begin
        w_ready_nxt[r_grant]  = 1'b1;
        w_result_nxt[r_grant] = r_mul_res;
      end
    end else if (r_state[S_RESP]) begin
      if (!w_gnt_req_valid) begin
        w_ready_nxt[r_grant] = 1'b0;
        w_last_grant_nxt     = r_grant;
      end
    end else begin
      w_mul_valid_nxt = 1'b0;
      w_ready_nxt     = 2'b00;
    end
  end

  // Output and datapath registers; last_grant=1 lets req0 win the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mul_valid  <= 1'b0;
      r_mul_req    <= '0;
      r_mul_res    <= '0;
      r_ready      <= 2'b00;
      r_result     <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_mul_valid  <= w_mul_valid_nxt;
      r_mul_req    <= w_mul_req_nxt;
      r_mul_res    <= w_mul_res_nxt;
      r_ready      <= w_ready_nxt;
      r_result     <= w_result_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  assign bus.mul_valid   = r_mul_valid;
  assign bus.mul_a       = r_mul_req.a;
  assign bus.mul_b       = r_mul_req.b;
  assign bus.mul_op      = r_mul_req.op;
  assign bus.req0_ready  = r_ready[0];
  assign bus.req1_ready  = r_ready[1];
  assign bus.req0_result = r_result[0];
  assign bus.req1_result = r_result[1];

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_arbiter                                                |
// | Description : Directed self-checking bench for mul_arbiter with a simple   |
// |               fixed-latency multiplier model.                               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mul_arbiter;
  import mul_arbiter_pkg::*;

`ifdef MUL_ARB_RESULT_CACHE_EN
  localparam int CACHE_ON = 1;
`else
  localparam int CACHE_ON = 0;
`endif

  logic clk = 1'b0;
  logic resetn;

  mul_arbiter_if bus();

  mul_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_errors   = 0;
  int mul_starts = 0;
  int mul_lat    = 2;
  int lat_cnt    = 0;
  logic prev_mv  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input mul_op_t op);
    logic [63:0] p;
    case (op)
      MUL_OP_MULH:  p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MUL_OP_MULSU: p = {{32{a[31]}}, a} * {32'b0, b};
      MUL_OP_MULU:  p = {32'b0, a} * {32'b0, b};
      default:      p = {32'b0, a} * {32'b0, b};
    endcase
    return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model: ready after mul_lat cycles, held until mul_valid drops.
  always @(negedge clk) begin
    if (bus.mul_valid && !prev_mv) mul_starts++;
    prev_mv = bus.mul_valid;
    if (!bus.mul_valid) begin
      bus.mul_ready  = 1'b0;
      bus.mul_result = 32'h0;
      lat_cnt        = 0;
    end else if (!bus.mul_ready) begin
      if (lat_cnt >= mul_lat) begin
        bus.mul_ready  = 1'b1;
        bus.mul_result = mul_ref(bus.mul_a, bus.mul_b, bus.mul_op);
      end else begin
        lat_cnt++;
      end
    end
  end

  task automatic set_req(input int idx, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input mul_op_t op);
    if (idx == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic wait_ready(input int idx, input string tag);
    int   n = 0;
    logic r;
    r = (idx == 0) ? bus.req0_ready : bus.req1_ready;
    while (r !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      r = (idx == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check(tag, 32'(r), 32'd1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   s0;
    logic saw_rdy;
    logic idle;

    resetn = 1'b0;
    set_req(0, 1'b0, 0, 0, MUL_OP_MUL);
    set_req(1, 1'b0, 0, 0, MUL_OP_MUL);
    cyc(3);

    // Reset state
    check("rst_mul_valid", 32'(bus.mul_valid), 0);
    check("rst_mul_a",     bus.mul_a, 0);
    check("rst_mul_op",    32'(bus.mul_op), 0);
    check("rst_rdy0",      32'(bus.req0_ready), 0);
    check("rst_rdy1",      32'(bus.req1_ready), 0);
    check("rst_res0",      bus.req0_result, 0);
    check("rst_state",     32'(dut.r_state), 1);
    resetn = 1'b1;
    cyc(1);

    // Single requester MUL 7x6
    set_req(0, 1'b1, 7, 6, MUL_OP_MUL);
    cyc(1);
    check("t1_mul_valid", 32'(bus.mul_valid), 1);
    check("t1_mul_a",     bus.mul_a, 7);
    check("t1_mul_b",     bus.mul_b, 6);
    check("t1_rdy1",      32'(bus.req1_ready), 0);
    wait_ready(0, "t1_rdy0");
    check("t1_result",    bus.req0_result, 42);
    cyc(2);
    check("t1_hold",      32'(bus.req0_ready), 1);
    set_req(0, 1'b0, 7, 6, MUL_OP_MUL);
    cyc(1);
    check("t1_drop",      32'(bus.req0_ready), 0);

    // Repeat of 7x6: cache hit when enabled, full transaction otherwise
    s0 = mul_starts;
    set_req(0, 1'b1, 7, 6, MUL_OP_MUL);
    cyc(1);
    if (CACHE_ON != 0) begin
      check("t5_hit_rdy", 32'(bus.req0_ready), 1);
      check("t5_hit_mv",  32'(bus.mul_valid), 0);
    end else begin
      check("t5_mv",      32'(bus.mul_valid), 1);
      check("t5_rdy0",    32'(bus.req0_ready), 0);
      wait_ready(0, "t5_wait");
    end
    check("t5_result", bus.req0_result, 42);
    set_req(0, 1'b0, 7, 6, MUL_OP_MUL);
    cyc(3);
    check("t5_starts", 32'(mul_starts), 32'(s0 + 1 - CACHE_ON));

    // Both requesting right after reset: req0 wins the first tie
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'h2, MUL_OP_MULH);
    set_req(1, 1'b1, 32'h8000_0000, 32'h2, MUL_OP_MULU);
    cyc(1);
    check("t2_mul_a",  bus.mul_a, 32'hFFFF_FFFF);
    check("t2_mul_op", 32'(bus.mul_op), 32'(MUL_OP_MULH));
    wait_ready(0, "t2_rdy0");
    check("t2_res0",   bus.req0_result, 32'hFFFF_FFFF);
    check("t2_rdy1",   32'(bus.req1_ready), 0);
    set_req(0, 1'b0, 0, 0, MUL_OP_MUL);
    wait_ready(1, "t2_rdy1w");
    check("t2_res1",   bus.req1_result, 32'h0000_0001);
    check("t2_rdy0",   32'(bus.req0_ready), 0);
    set_req(1, 1'b0, 0, 0, MUL_OP_MUL);
    cyc(2);

    // req0 re-requests back-to-back while req1 waits: req1 must be next
    set_req(0, 1'b1, 3, 5, MUL_OP_MUL);
    set_req(1, 1'b1, 4, 4, MUL_OP_MUL);
    cyc(1);
    check("t3_first", bus.mul_a, 3);
    wait_ready(0, "t3_rdy0");
    check("t3_res0",  bus.req0_result, 15);
    set_req(0, 1'b0, 3, 5, MUL_OP_MUL);
    cyc(1);
    set_req(0, 1'b1, 3, 5, MUL_OP_MUL);
    cyc(1);
    check("t3_regrant", bus.mul_a, 4);
    check("t3_rdy0",    32'(bus.req0_ready), 0);
    wait_ready(1, "t3_rdy1");
    check("t3_res1",    bus.req1_result, 16);
    set_req(1, 1'b0, 4, 4, MUL_OP_MUL);
    wait_ready(0, "t3_rdy0b");
    check("t3_res0b",   bus.req0_result, 15);
    set_req(0, 1'b0, 3, 5, MUL_OP_MUL);
    cyc(2);

    // Reset while BUSY
    set_req(0, 1'b1, 9, 9, MUL_OP_MUL);
    cyc(1);
    check("t4_busy", 32'(bus.mul_valid), 1);
    resetn = 1'b0;
    cyc(1);
    check("t4_mv",    32'(bus.mul_valid), 0);
    check("t4_rdy0",  32'(bus.req0_ready), 0);
    check("t4_rdy1",  32'(bus.req1_ready), 0);
    check("t4_state", 32'(dut.r_state), 1);
    set_req(0, 1'b1, 10, 11, MUL_OP_MUL);
    resetn = 1'b1;
    wait_ready(0, "t4_rdy0w");
    check("t4_res0",  bus.req0_result, 110);
    set_req(0, 1'b0, 10, 11, MUL_OP_MUL);
    cyc(2);

    // req1 abandons during BUSY
    set_req(1, 1'b1, 5, 5, MUL_OP_MUL);
    cyc(1);
    check("t6_busy", 32'(bus.mul_valid), 1);
    set_req(1, 1'b0, 5, 5, MUL_OP_MUL);
    saw_rdy = 1'b0;
    idle    = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.req1_ready) saw_rdy = 1'b1;
      if (dut.r_state == 4'b0001) begin
        idle = 1'b1;
        break;
      end
    end
    check("t6_no_rdy", 32'(saw_rdy), 0);
    check("t6_idle",   32'(idle), 1);
    check("t6_mv",     32'(bus.mul_valid), 0);
    s0 = mul_starts;
    set_req(1, 1'b1, 5, 5, MUL_OP_MUL);
    wait_ready(1, "t6_rdy1");
    check("t6_res1",   bus.req1_result, 25);
    set_req(1, 1'b0, 5, 5, MUL_OP_MUL);
    cyc(3);
    check("t6_starts", 32'(mul_starts), 32'(s0 + 1 - CACHE_ON));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
